// File: rtl/text_braille_top.sv
// Letter-to-Braille encoder.
// Decodes a one-hot letter code ('a'..'z') into the six dots of a Braille cell.
// Dots and the error flag are registered, giving one cycle of latency.
// Any code that is not exactly one-hot yields a blank cell with err raised.
module text_braille_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [25:0] alp,
    output logic        Of1,
    output logic        Of2,
    output logic        Of3,
    output logic        Of4,
    output logic        Of5,
    output logic        Of6,
    output logic        err
);

    // Cell pattern per letter, packed as {dot1, dot2, dot3, dot4, dot5, dot6}.
    localparam logic [5:0] DOT_TABLE [0:25] = '{
        6'b100000,  // a
        6'b110000,  // b
        6'b100100,  // c
        6'b100110,  // d
        6'b100010,  // e
        6'b110100,  // f
        6'b110110,  // g
        6'b110010,  // h
        6'b010100,  // i
        6'b010110,  // j
        6'b101000,  // k
        6'b111000,  // l
        6'b101100,  // m
        6'b101110,  // n
        6'b101010,  // o
        6'b111100,  // p
        6'b111110,  // q
        6'b111010,  // r
        6'b011100,  // s
        6'b011110,  // t
        6'b101001,  // u
        6'b111001,  // v
        6'b010111,  // w
        6'b101101,  // x
        6'b101111,  // y
        6'b101011   // z
    };

    logic [5:0] dots_d;
    logic [5:0] dots_q;
    logic       err_d;
    logic       err_q;
    logic       one_hot;
    logic [5:0] letter_dots [0:25];

    // Each selected letter contributes its pattern; at most one is non-zero
    // whenever the result is actually used.
    genvar gi;
    generate
        for (gi = 0; gi < 26; gi++) begin : g_letter
            assign letter_dots[gi] = alp[gi] ? DOT_TABLE[gi] : 6'b000000;
        end
    endgenerate

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    always_comb begin
        one_hot = (alp != 26'd0) && ((alp & (alp - 26'd1)) == 26'd0);
    end

    // Next-state decode; invalid codes blank the cell instead of merging patterns.
    always_comb begin
        dots_d = 6'b000000;
        err_d  = ~one_hot;
        if (one_hot) begin
            for (int k = 0; k < 26; k++) begin
                dots_d = dots_d | letter_dots[k];
            end
        end
    end

    // Output register; reset blanks the cell and clears err immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dots_q <= 6'b000000;
            err_q  <= 1'b0;
        end else begin
            dots_q <= dots_d;
            err_q  <= err_d;
        end
    end

    assign Of1 = dots_q[5];
    assign Of2 = dots_q[4];
    assign Of3 = dots_q[3];
    assign Of4 = dots_q[2];
    assign Of5 = dots_q[1];
    assign Of6 = dots_q[0];
    assign err = err_q;

endmodule

// File: tb/tb_text_braille_top.sv
// Testbench for text_braille_top: directed steps with a scoreboard queue.
// Expected cells come from a structural Braille model (decade rows a-j, +dot3, +dot3/6).
module tb_text_braille_top;

    logic        clk;
    logic        rst_n;
    logic [25:0] alp;
    logic        Of1, Of2, Of3, Of4, Of5, Of6, err;

    int n_checks;
    int n_fails;

    // Each entry: {err, dot1..dot6}
    logic [6:0] sb_q [$];

    text_braille_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alp   (alp),
        .Of1   (Of1),
        .Of2   (Of2),
        .Of3   (Of3),
        .Of4   (Of4),
        .Of5   (Of5),
        .Of6   (Of6),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] dot(input int n);
        dot = 6'b100000 >> (n - 1);
    endfunction

    // Base patterns of the first decade (dots 1,2,4,5 only).
    function automatic logic [5:0] decade(input int i);
        case (i)
            0: decade = dot(1);
            1: decade = dot(1) | dot(2);
            2: decade = dot(1) | dot(4);
            3: decade = dot(1) | dot(4) | dot(5);
            4: decade = dot(1) | dot(5);
            5: decade = dot(1) | dot(2) | dot(4);
            6: decade = dot(1) | dot(2) | dot(4) | dot(5);
            7: decade = dot(1) | dot(2) | dot(5);
            8: decade = dot(2) | dot(4);
            default: decade = dot(2) | dot(4) | dot(5);
        endcase
    endfunction

    function automatic logic [6:0] model(input logic [25:0] a);
        int idx;
        logic [5:0] d;
        if ($countones(a) != 1) return {1'b1, 6'b000000};
        idx = 0;
        for (int k = 0; k < 26; k++) if (a[k]) idx = k;
        if (idx < 10)       d = decade(idx);
        else if (idx < 20)  d = decade(idx - 10) | dot(3);
        else if (idx == 22) d = decade(9) | dot(6);                 // w
        else if (idx < 22)  d = decade(idx - 20) | dot(3) | dot(6); // u, v
        else                d = decade(idx - 21) | dot(3) | dot(6); // x, y, z
        return {1'b0, d};
    endfunction

    function automatic logic [6:0] observed();
        return {err, Of1, Of2, Of3, Of4, Of5, Of6};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s observed err,dots=%b expected=%b", tag, obs, exp_v);
        end
        $display("check %-14s alp=%07h err,dots=%b expected=%b", tag, alp, obs, exp_v);
    endtask

    // Drive one letter between edges, push its expectation, compare just after the edge.
    task automatic step(input string tag, input logic [25:0] a, input logic [6:0] exp_v);
        logic [6:0] e;
        @(negedge clk);
        alp = a;
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check(tag, observed(), e);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        alp      = 26'h1;

        // Reset held low across edges keeps the cell blank.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", observed(), 7'b0_000000);
        @(negedge clk);
        rst_n = 1'b1;
        step("first_after_rst", 26'h1, 7'b0_100000);

        // Walking one a..z against the model, with table constants on key letters.
        for (int k = 0; k < 26; k++) begin
            logic [25:0] a;
            a = 26'h1 << k;
            step($sformatf("walk_%c", 8'h61 + k), a, model(a));
        end
        step("const_j", 26'h1 << 9,  7'b0_010110);
        step("const_t", 26'h1 << 19, 7'b0_011110);
        step("const_w", 26'h1 << 22, 7'b0_010111);
        step("const_z", 26'h1 << 25, 7'b0_101011);

        // Invalid codes blank the cell and raise err.
        step("zero",      26'h0,       7'b1_000000);
        step("after_c",   26'h4,       7'b0_100100);
        step("multi_ab",  26'h3,       7'b1_000000);
        step("all_ones",  26'h3FFFFFF, 7'b1_000000);
        step("multi_far", 26'h2000001, model(26'h2000001));

        // Async reset while err is high clears it without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_clr_err", observed(), 7'b0_000000);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-stream of 'y'.
        step("stream_y", 26'h1 << 24, 7'b0_101111);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", observed(), 7'b0_000000);
        @(posedge clk);
        #1;
        check("rst_held", observed(), 7'b0_000000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_y", 26'h1 << 24, 7'b0_101111);

        // Back-to-back change e -> q.
        step("b2b_e", 26'h1 << 4,  7'b0_100010);
        step("b2b_q", 26'h1 << 16, 7'b0_111110);

        // Random one-hot and random multi-bit codes against the model.
        for (int r = 0; r < 20; r++) begin
            logic [25:0] a;
            if (r % 2 == 0) a = 26'h1 << $urandom_range(25);
            else            a = 26'($urandom);
            step("random", a, model(a));
        end

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_leftover remaining=%0d required=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
